// File: rtl/hemaia_reset_seq_pkg.sv
// Shared types and default timing constants for the HeMAiA reset sequencer.
package hemaia_reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    GAP     = 3'd3,
    DONE    = 3'd4
  } rst_seq_state_e;

  localparam int unsigned DefNumReset   = 4;
  localparam int unsigned DefHoldCycles = 16;
  localparam int unsigned DefGapCycles  = 8;
  localparam int unsigned DefAckTimeout = 1024;

endpackage

// File: rtl/hemaia_reset_ack_sync.sv
// Per-bit two-flop synchroniser that brings the reset controller's
// acknowledge lines into the always-on clock domain.
module hemaia_reset_ack_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] async_i,
  output logic [Width-1:0] sync_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Two-stage capture; both stages clear to "domain in reset".
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/hemaia_reset_sequencer.sv
// Always-on reset sequencer: asserts a set of domain resets together, holds
// them, then releases them one at a time, lowest index first.
// Optional macro HEMAIA_RST_SEQ_ACK_EN adds per-domain acknowledge wait
// (rst_ack_ni) with a sticky per-domain timeout flag (timeout_o).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for a request, all outputs stable
// HOLD    | requested lines low, counting the hold time
// RELEASE | raise the lowest pending line (one cycle)
// GAP     | optional ack wait, then count the gap before next release
// DONE    | one-cycle completion pulse, then back to IDLE
module hemaia_reset_sequencer
  import hemaia_reset_seq_pkg::*;
#(
  parameter int unsigned NumReset   = DefNumReset,
  parameter int unsigned HoldCycles = DefHoldCycles,
  parameter int unsigned GapCycles  = DefGapCycles,
  parameter int unsigned AckTimeout = DefAckTimeout
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  input  logic [NumReset-1:0] req_mask_i,
  output logic                req_ready_o,
  output logic [NumReset-1:0] local_rst_no,
  output logic                busy_o,
  output logic                done_o
`ifdef HEMAIA_RST_SEQ_ACK_EN
  ,
  input  logic [NumReset-1:0] rst_ack_ni,
  output logic [NumReset-1:0] timeout_o
`endif
);

  localparam int unsigned MaxHg  = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int unsigned MaxCnt = (MaxHg > AckTimeout) ? MaxHg : AckTimeout;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  // Boot preloads the full hold count so that the first edge after reset
  // behaves like an accept edge (channel 0 rises at edge HoldCycles+1).
  localparam logic [CntW-1:0] HoldBoot  = CntW'(HoldCycles);
  localparam logic [CntW-1:0] HoldStart = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLoad   = CntW'(GapCycles - 1);
  // After the final release the gap runs one cycle longer so DONE is
  // entered on the edge at last release + GapCycles + 1.
  localparam logic [CntW-1:0] GapLast   = CntW'(GapCycles);
  localparam logic [CntW-1:0] AckLoad   = CntW'(AckTimeout - 1);

  rst_seq_state_e      state_q;
  logic [CntW-1:0]     cnt_q;
  logic [NumReset-1:0] pend_q;
  logic [NumReset-1:0] lines_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic [NumReset-1:0] rel_sel;
  logic [NumReset-1:0] pend_after;

  // Priority encoder: one-hot of the lowest-index pending channel.
  always_comb begin
    rel_sel = '0;
    for (int i = NumReset - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        rel_sel    = '0;
        rel_sel[i] = 1'b1;
      end
    end
  end

  assign pend_after = pend_q & ~rel_sel;

`ifdef HEMAIA_RST_SEQ_ACK_EN
  logic [NumReset-1:0] ack_sync;
  logic [NumReset-1:0] chan_q;
  logic [NumReset-1:0] timeout_q;
  logic                ack_wait_q;

  hemaia_reset_ack_sync #(
    .Width (NumReset)
  ) i_ack_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .async_i (rst_ack_ni),
    .sync_o  (ack_sync)
  );

  // Ack-wait bookkeeping: which channel was just released and its timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chan_q     <= '0;
      timeout_q  <= '0;
      ack_wait_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        timeout_q <= '0;
      end
      if (state_q == RELEASE) begin
        chan_q     <= rel_sel;
        ack_wait_q <= 1'b1;
      end else if (state_q == GAP && ack_wait_q) begin
        if (|(ack_sync & chan_q)) begin
          ack_wait_q <= 1'b0;
        end else if (cnt_q == '0) begin
          ack_wait_q <= 1'b0;
          timeout_q  <= timeout_q | chan_q;
        end
      end
    end
  end

  assign timeout_o = timeout_q;
`endif

  // Sequencer FSM; outputs are registered alongside the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HOLD;
      cnt_q   <= HoldBoot;
      pend_q  <= '1;
      lines_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            if (|req_mask_i) begin
              state_q <= HOLD;
              cnt_q   <= HoldStart;
              pend_q  <= req_mask_i;
              lines_q <= lines_q & ~req_mask_i;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= RELEASE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RELEASE: begin
          lines_q <= lines_q | rel_sel;
          pend_q  <= pend_after;
          state_q <= GAP;
`ifdef HEMAIA_RST_SEQ_ACK_EN
          cnt_q   <= AckLoad;
`else
          cnt_q   <= (|pend_after) ? GapLoad : GapLast;
`endif
        end
        GAP: begin
`ifdef HEMAIA_RST_SEQ_ACK_EN
          if (ack_wait_q) begin
            if (|(ack_sync & chan_q) || cnt_q == '0) begin
              cnt_q <= (|pend_q) ? GapLoad : GapLast;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end else
`endif
          if (cnt_q == '0) begin
            if (|pend_q) begin
              state_q <= RELEASE;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign local_rst_no = lines_q;

endmodule
